hamming_deserializador: RTL and testbench

Bit-serial receiver for the Hamming(15,11) channel. It sits directly downstream of the error-injection/channel stage. It assembles 15-bit codewords from a serial stream, computes the syndrome, corrects any single-bit error, and emits the 11-bit data word with status. It replaces the combinational corrector on serial links and adds framing and error statistics.

---
 rtl/hamming_deserializador.sv | 119 +++++++++++
 tb/tb_hamming_deserializador.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_deserializador.sv
// hamming_deserializador
// Bit-serial Hamming(15,11) receiver. Frames 15-bit codewords from a serial
// stream (position 1 first), computes the syndrome, flips the addressed bit
// when the syndrome is non-zero and delivers the 11 data bits with status.
//
// Optional feature macro: HAMMING_CONTADOR_EN
//   defined   -> saturating corrected-error counter, cleared by limpa_contador
//   undefined -> contador_erros tied to 0, limpa_contador ignored
//
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous reset, active-high
//   serial_in       received codeword bit
//   serial_valid    serial_in holds a valid bit this cycle
//   sinc            with serial_valid: this bit is position 1 of a new frame
//   limpa_contador  synchronous clear of contador_erros
//   dado_out        corrected 11-bit data word (held until next delivery)
//   dado_valido     one-cycle pulse per delivered frame
//   erro_corrigido  delivered word had a non-zero syndrome
//   sindrome        syndrome of the delivered word
//   contador_erros  saturating count of corrected deliveries
module hamming_deserializador #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             sinc,
    input  logic             limpa_contador,
    output logic [10:0]      dado_out,
    output logic             dado_valido,
    output logic             erro_corrigido,
    output logic [3:0]       sindrome,
    output logic [CNT_W-1:0] contador_erros
);

    typedef enum logic [0:0] {StOcioso, StRecebe} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    // Positions 1..14; position 15 is taken straight from serial_in.
    logic [13:0] sr_q;

    logic [14:0] frame;
    logic [14:0] corrected;
    logic [3:0]  synd;
    logic [10:0] data;
    logic        frame_done;

    always_comb begin
        frame = {serial_in, sr_q};
        synd  = '0;
        for (int k = 0; k < 15; k++) begin
            if (frame[k]) synd = synd ^ 4'(k + 1);
        end
        corrected = frame;
        if (synd != 4'd0) corrected[synd - 4'd1] = ~corrected[synd - 4'd1];
        // Data positions 3,5,6,7,9..15 -> d0..d10
        data = {corrected[14:8], corrected[6:4], corrected[2]};
    end

    // Position 15 being accepted this cycle; sinc overrides it (resync).
    assign frame_done = serial_valid && !sinc && (state_q == StRecebe) && (cnt_q == 4'd14);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StOcioso;
            cnt_q          <= '0;
            sr_q           <= '0;
            dado_out       <= '0;
            dado_valido    <= 1'b0;
            erro_corrigido <= 1'b0;
            sindrome       <= '0;
        end else begin
            dado_valido <= 1'b0;
            if (serial_valid) begin
                if (sinc) begin
                    // Start of a frame; any partial frame is dropped silently.
                    sr_q[0] <= serial_in;
                    cnt_q   <= 4'd1;
                    state_q <= StRecebe;
                end else if (state_q == StRecebe) begin
                    if (frame_done) begin
                        dado_out       <= data;
                        sindrome       <= synd;
                        erro_corrigido <= (synd != 4'd0);
                        dado_valido    <= 1'b1;
                        cnt_q          <= '0;
                    end else begin
                        sr_q[cnt_q] <= serial_in;
                        cnt_q       <= cnt_q + 4'd1;
                    end
                end
            end
        end
    end

`ifdef HAMMING_CONTADOR_EN
    logic [CNT_W-1:0] cnt_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_err_q <= '0;
        end else if (limpa_contador) begin
            cnt_err_q <= '0;
        end else if (frame_done && (synd != 4'd0) && !(&cnt_err_q)) begin
            cnt_err_q <= cnt_err_q + 1'b1;
        end
    end

    assign contador_erros = cnt_err_q;
`else
    logic unused_limpa;
    assign unused_limpa   = limpa_contador;
    assign contador_erros = '0;
`endif

endmodule

// File: tb/tb_hamming_deserializador.sv
module tb_hamming_deserializador;

    logic        clk;
    logic        rst;
    logic        serial_in;
    logic        serial_valid;
    logic        sinc;
    logic        limpa_contador;
    logic [10:0] dado_out;
    logic        dado_valido;
    logic        erro_corrigido;
    logic [3:0]  sindrome;
    logic [1:0]  contador_erros;

    hamming_deserializador #(.CNT_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .serial_valid   (serial_valid),
        .sinc           (sinc),
        .limpa_contador (limpa_contador),
        .dado_out       (dado_out),
        .dado_valido    (dado_valido),
        .erro_corrigido (erro_corrigido),
        .sindrome       (sindrome),
        .contador_erros (contador_erros)
    );

    typedef struct {
        logic [10:0] d;
        logic [3:0]  s;
        logic        e;
        logic [1:0]  c;
        int          stamp;
    } exp_t;

    exp_t       sb[$];
    exp_t       got_exp;
    int         n_vec;
    int         n_err;
    int         cyc;
    logic [1:0] exp_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Independent encoder: data into non-power-of-two positions, then parities.
    function automatic logic [14:0] encode(input logic [10:0] d);
        logic [14:0] c;
        int          di;
        logic        p;
        c  = '0;
        di = 0;
        for (int pos = 1; pos <= 15; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[di];
                di++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            p = 1'b0;
            for (int pos = 1; pos <= 15; pos++) begin
                if (((pos >> j) & 1) != 0) p = p ^ c[pos-1];
            end
            c[(1 << j) - 1] = p;
        end
        return c;
    endfunction

    task automatic push_exp(input logic [10:0] d, input logic [3:0] s, input bit clr);
        exp_t x;
        logic e;
        e = (s != 4'd0);
        if (clr) exp_cnt = 2'd0;
        else if (e && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
        x.d = d;
        x.s = s;
        x.e = e;
`ifdef HAMMING_CONTADOR_EN
        x.c = exp_cnt;
`else
        x.c = 2'd0;
`endif
        x.stamp = cyc + 1;
        sb.push_back(x);
    endtask

    task automatic drive(input logic b, input logic v, input logic s, input logic l);
        serial_in      = b;
        serial_valid   = v;
        sinc           = s;
        limpa_contador = l;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [14:0] cw, input logic [10:0] ed, input logic [3:0] es,
                              input bit sync, input bit gaps, input bit clr);
        for (int i = 0; i < 15; i++) begin
            if (gaps && i > 0) begin
                repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            if (i == 14) push_exp(ed, es, clr);
            drive(cw[i], 1'b1, sync && (i == 0), clr && (i == 14));
        end
    endtask

    task automatic send_partial(input logic [14:0] cw, input int n);
        for (int i = 0; i < n; i++) drive(cw[i], 1'b1, i == 0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_eq({pfx, "_dado_out"}, 32'(dado_out), 32'h0);
        check_eq({pfx, "_dado_valido"}, 32'(dado_valido), 32'h0);
        check_eq({pfx, "_erro_corrigido"}, 32'(erro_corrigido), 32'h0);
        check_eq({pfx, "_sindrome"}, 32'(sindrome), 32'h0);
        check_eq({pfx, "_contador_erros"}, 32'(contador_erros), 32'h0);
    endtask

    // Scoreboard: every pulse pops one expectation and must land on its cycle.
    always @(negedge clk) begin
        if (!rst && dado_valido) begin
            if (sb.size() == 0) begin
                check_eq("pulse_unexpected", 32'd1, 32'd0);
            end else begin
                got_exp = sb.pop_front();
                check_eq("dado_out", 32'(dado_out), 32'(got_exp.d));
                check_eq("sindrome", 32'(sindrome), 32'(got_exp.s));
                check_eq("erro_corrigido", 32'(erro_corrigido), 32'(got_exp.e));
                check_eq("contador_erros", 32'(contador_erros), 32'(got_exp.c));
                check_eq("latency_cycle", 32'(cyc), 32'(got_exp.stamp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] d;
        logic [14:0] cw;
        int          pos;

        n_vec          = 0;
        n_err          = 0;
        cyc            = 0;
        exp_cnt        = 2'd0;
        rst            = 1'b0;
        serial_in      = 1'b0;
        serial_valid   = 1'b0;
        sinc           = 1'b0;
        limpa_contador = 1'b0;
        #2 rst = 1'b1;
        #1 check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Clean frame
        send_frame(15'h7FFF, 11'h7FF, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(3);
        // Position 5 flipped
        send_frame(15'h7FEF, 11'h7FF, 4'd5, 1'b1, 1'b0, 1'b0);
        idle(3);
        // Back-to-back, second frame has no sinc
        send_frame(15'h0007, 11'h001, 4'd0, 1'b1, 1'b0, 1'b0);
        send_frame(15'h0003, 11'h001, 4'd3, 1'b0, 1'b0, 1'b0);
        idle(3);
        // Aborted partial frame, gap with stray sinc, then resync
        send_partial(15'h7FFF, 7);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);
        send_frame(15'h7FFF, 11'h7FF, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(2);
        // Resync with no gap after 10 bits
        send_partial(15'h0000, 10);
        send_frame(15'h7FFF, 11'h7FF, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Random single-error frames with gaps: counter saturates at 3, then cleared
        for (int n = 0; n < 3; n++) begin
            d   = 11'($urandom) | 11'h1;
            cw  = encode(d);
            pos = $urandom_range(1, 15);
            cw[pos-1] = ~cw[pos-1];
            send_frame(cw, d, 4'(pos), 1'b1, 1'b1, n == 2);
            idle(2);
        end

        // Clean and errored random frames so outputs are non-zero before reset
        d = 11'($urandom) | 11'h1;
        send_frame(encode(d), d, 4'd0, 1'b1, 1'b1, 1'b0);
        idle(2);
        d  = 11'($urandom) | 11'h2;
        cw = encode(d);
        cw[14] = ~cw[14];
        send_frame(cw, d, 4'd15, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Asynchronous reset between edges after 8 bits
        send_partial(15'h7FFF, 8);
        #2 rst = 1'b1;
        #1 check_outputs_zero("async_reset");
        exp_cnt = 2'd0;
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        send_frame(15'h0007, 11'h001, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(20);

        check_eq("pending_pulses", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
